// File: rtl/branch_predictor_ctrl_if.sv
// Lookup/update channel between the IF/EX stages and the branch predictor controller.
interface branch_predictor_ctrl_if;
  logic        lk_valid;
  logic [31:0] lk_pc;
  logic        lk_ready;
  logic        pred_valid;
  logic        pred_taken;
  logic        up_valid;
  logic [31:0] up_pc;
  logic        up_taken;
  logic        up_ready;
  logic        upd_pending;

  modport master (
    output lk_valid, lk_pc, up_valid, up_pc, up_taken,
    input  lk_ready, pred_valid, pred_taken, up_ready, upd_pending
  );

  modport slave (
    input  lk_valid, lk_pc, up_valid, up_pc, up_taken,
    output lk_ready, pred_valid, pred_taken, up_ready, upd_pending
  );
endinterface

// File: rtl/branch_predictor_ctrl.sv
// Single-port PHT of 2-bit counters shared between IF lookups and buffered EX updates.
// Define GSHARE_EN to XOR a global history register into the table index.
module branch_predictor_ctrl #(
  parameter int unsigned IDX_W     = 4,
  parameter int unsigned UPD_DEPTH = 4,
  parameter int unsigned GHR_W     = 4
) (
  input logic                    clk,
  input logic                    reset,
  branch_predictor_ctrl_if.slave bp
);

  localparam int unsigned Entries = 1 << IDX_W;
  localparam int unsigned PtrW    = $clog2(UPD_DEPTH);
  localparam int unsigned CntW    = PtrW + 1;

  if (GHR_W > IDX_W) begin : g_ghr_w_check
    $error("GHR_W must not exceed IDX_W");
  end
  if (UPD_DEPTH < 2 || (UPD_DEPTH & (UPD_DEPTH - 1)) != 0) begin : g_depth_check
    $error("UPD_DEPTH must be a power of 2 and at least 2");
  end

  logic [1:0]       r_pht      [Entries];
  logic [IDX_W-1:0] r_fifo_idx [UPD_DEPTH];
  logic             r_fifo_tkn [UPD_DEPTH];
  logic [PtrW-1:0]  r_rd_ptr;
  logic [PtrW-1:0]  r_wr_ptr;
  logic [CntW-1:0]  r_count;
  logic             r_pred_valid;
  logic             r_pred_taken;

  logic             w_full;
  logic             w_empty;
  logic             w_lookup;
  logic             w_push;
  logic             w_drain;
  logic [IDX_W-1:0] w_lk_idx;
  logic [IDX_W-1:0] w_up_idx;
  logic [IDX_W-1:0] w_head_idx;
  logic             w_head_tkn;
  logic [1:0]       w_head_cnt;
  logic [1:0]       w_next_cnt;
  logic             w_unused_pc;

`ifdef GSHARE_EN
  logic [GHR_W-1:0] r_ghr;

  assign w_lk_idx = bp.lk_pc[IDX_W+1:2] ^ IDX_W'(r_ghr);
  assign w_up_idx = bp.up_pc[IDX_W+1:2] ^ IDX_W'(r_ghr);

  // History shifts on accepted updates; the stored index used the pre-shift value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ghr <= '0;
    end else if (w_push) begin
      if (GHR_W > 1) r_ghr <= {r_ghr[GHR_W-2:0], bp.up_taken};
      else           r_ghr <= GHR_W'(bp.up_taken);
    end
  end
`else
  assign w_lk_idx = bp.lk_pc[IDX_W+1:2];
  assign w_up_idx = bp.up_pc[IDX_W+1:2];
`endif

  assign w_unused_pc = ^{bp.lk_pc[31:IDX_W+2], bp.lk_pc[1:0],
                         bp.up_pc[31:IDX_W+2], bp.up_pc[1:0]};

  // Port grant: a full FIFO wins, then lookups, then opportunistic drains.
  assign w_full   = (r_count == CntW'(UPD_DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_lookup = !reset && bp.lk_valid && !w_full;
  assign w_push   = !reset && bp.up_valid && !w_full;
  assign w_drain  = !reset && !w_empty && (w_full || !bp.lk_valid);

  assign w_head_idx = r_fifo_idx[r_rd_ptr];
  assign w_head_tkn = r_fifo_tkn[r_rd_ptr];
  assign w_head_cnt = r_pht[w_head_idx];

  always_comb begin
    w_next_cnt = w_head_cnt;
    if (w_head_tkn) begin
      if (w_head_cnt != 2'b11) w_next_cnt = w_head_cnt + 2'd1;
    end else begin
      if (w_head_cnt != 2'b00) w_next_cnt = w_head_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(Entries); i++) r_pht[i] <= 2'b01;
    end else if (w_drain) begin
      r_pht[w_head_idx] <= w_next_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_idx[r_wr_ptr] <= w_up_idx;
      r_fifo_tkn[r_wr_ptr] <= bp.up_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)  r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_drain) r_rd_ptr <= r_rd_ptr + PtrW'(1);
      case ({w_push, w_drain})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Prediction reads the table as it stood before this edge (no bypass).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pred_valid <= 1'b0;
      r_pred_taken <= 1'b0;
    end else begin
      r_pred_valid <= w_lookup;
      if (w_lookup) r_pred_taken <= r_pht[w_lk_idx][1];
    end
  end

  assign bp.lk_ready    = !w_full;
  assign bp.up_ready    = !w_full;
  assign bp.upd_pending = !w_empty;
  assign bp.pred_valid  = r_pred_valid;
  assign bp.pred_taken  = r_pred_taken;

endmodule

// File: tb/tb_branch_predictor_ctrl.sv
// Randomized scoreboard bench for branch_predictor_ctrl against a table/queue reference model.
module tb_branch_predictor_ctrl;

  localparam int ENTRIES = 16;
  localparam int DEPTH   = 4;
  localparam int GHRW    = 4;

  typedef struct {
    int idx;
    bit tkn;
  } upd_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  branch_predictor_ctrl_if bp_if();

  branch_predictor_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bp    (bp_if)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  bit   started  = 1'b0;
  int   m_pht [ENTRIES];
  upd_t m_q [$];
  int   m_ghr = 0;
  bit   exp_q [$];
  bit   last_taken = 1'b0;
  bit   seen_lk_ready;

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  function automatic int pc_idx(logic [31:0] pc);
    int idx = int'((pc >> 2) % ENTRIES);
`ifdef GSHARE_EN
    idx = idx ^ m_ghr;
`endif
    return idx;
  endfunction

  // One cycle of the reference model, applied with the inputs presented this cycle.
  function automatic void model_step(bit rst, bit lv, logic [31:0] lpc,
                                     bit uv, logic [31:0] upc, bit ut);
    bit full;
    bit lookup;
    bit push;
    bit drain;
    upd_t e;
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) m_pht[i] = 1;
      m_q.delete();
      m_ghr = 0;
      return;
    end
    full   = (m_q.size() == DEPTH);
    lookup = lv && !full;
    push   = uv && !full;
    drain  = (m_q.size() > 0) && (full || !lv);
    if (lookup) exp_q.push_back(m_pht[pc_idx(lpc)] >= 2);
    if (drain) begin
      e = m_q.pop_front();
      if (e.tkn) m_pht[e.idx] = (m_pht[e.idx] == 3) ? 3 : m_pht[e.idx] + 1;
      else       m_pht[e.idx] = (m_pht[e.idx] == 0) ? 0 : m_pht[e.idx] - 1;
    end
    if (push) begin
      e.idx = pc_idx(upc);
      e.tkn = ut;
      m_q.push_back(e);
      m_ghr = ((m_ghr << 1) | int'(ut)) % (1 << GHRW);
    end
  endfunction

  task automatic cyc(input bit rst, input bit lv, input logic [31:0] lpc,
                     input bit uv, input logic [31:0] upc, input bit ut);
    @(negedge clk);
    seen_lk_ready = bp_if.lk_ready;
    if (started) begin
      chk("lk_ready",    int'(bp_if.lk_ready),    int'(m_q.size() != DEPTH));
      chk("up_ready",    int'(bp_if.up_ready),    int'(m_q.size() != DEPTH));
      chk("upd_pending", int'(bp_if.upd_pending), int'(m_q.size() != 0));
    end
    reset            = rst;
    bp_if.lk_valid   = lv;
    bp_if.lk_pc      = lpc;
    bp_if.up_valid   = uv;
    bp_if.up_pc      = upc;
    bp_if.up_taken   = ut;
    started          = 1'b1;
    model_step(rst, lv, lpc, uv, upc, ut);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 32'h0, 0, 32'h0, 0);
  endtask

  // Monitor: compares every presented prediction against the queued expectation.
  initial begin
    bit e;
    forever begin
      @(posedge clk);
      #1;
      if (!started) continue;
      if (reset) begin
        chk("rst_pred_valid", int'(bp_if.pred_valid), 0);
        chk("rst_pred_taken", int'(bp_if.pred_taken), 0);
        last_taken = 1'b0;
        exp_q.delete();
        continue;
      end
      chk("pred_valid", int'(bp_if.pred_valid), int'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (bp_if.pred_valid) chk("pred_taken", int'(bp_if.pred_taken), int'(e));
        last_taken = e;
      end else if (!bp_if.pred_valid) begin
        chk("pred_hold", int'(bp_if.pred_taken), int'(last_taken));
      end
    end
  end

  initial begin
    int not_ready;
    bp_if.lk_valid = 1'b0;
    bp_if.lk_pc    = '0;
    bp_if.up_valid = 1'b0;
    bp_if.up_pc    = '0;
    bp_if.up_taken = 1'b0;

    // Reset, then first lookup of a weakly-not-taken entry
    cyc(1, 0, 32'h0, 0, 32'h0, 0);
    cyc(1, 0, 32'h0, 0, 32'h0, 0);
    cyc(0, 1, 32'h10, 0, 32'h0, 0);
    idle(1);

    // Three taken updates saturate entry 4, then look it up
    for (int i = 0; i < 3; i++) cyc(0, 0, 32'h0, 1, 32'h10, 1);
    idle(4);
    cyc(0, 1, 32'h10, 0, 32'h0, 0);
    idle(1);

    // Back-to-back pushes under a continuous lookup stream fill the FIFO once
    not_ready = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 32'h20 + 32'(i * 4), 1, 32'h40 + 32'(i * 4), 1);
      if (!seen_lk_ready) not_ready++;
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 32'h10, 0, 32'h0, 0);
      if (!seen_lk_ready) not_ready++;
    end
    cyc(0, 0, 32'h0, 0, 32'h0, 0);
    if (!seen_lk_ready) not_ready++;
    chk("t3_full_cycles", not_ready, 1);
    idle(4);

    // Same-cycle update and lookup of entry 4: no bypass
    cyc(0, 1, 32'h10, 1, 32'h10, 0);
    idle(2);
    cyc(0, 1, 32'h10, 0, 32'h0, 0);
    idle(2);

    // Reset with updates pending and entry 4 strongly taken
    for (int i = 0; i < 3; i++) cyc(0, 0, 32'h0, 1, 32'h10, 1);
    idle(3);
    for (int i = 0; i < 3; i++) cyc(0, 1, 32'h14, 1, 32'h10, 0);
    cyc(1, 1, 32'h10, 1, 32'h10, 1);
    cyc(0, 1, 32'h10, 0, 32'h0, 0);
    idle(1);

`ifdef GSHARE_EN
    // Four taken updates saturate the history, then look up 0x10
    for (int i = 0; i < 4; i++) cyc(0, 0, 32'h0, 1, 32'h10, 1);
    idle(5);
    cyc(0, 1, 32'h10, 0, 32'h0, 0);
    idle(1);
`endif

    // Randomized traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 149) == 0,
          $urandom_range(0, 99) < 60, $urandom(),
          $urandom_range(0, 99) < 55, $urandom(),
          1'($urandom_range(0, 1)));
    end

    // Drain, then sweep the whole table
    idle(DEPTH + 2);
    for (int i = 0; i < ENTRIES; i++) cyc(0, 1, 32'(i * 4), 0, 32'h0, 0);
    idle(3);
    chk("exp_q_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
